// File: rtl/decode_stage.sv
// Purpose: MIPS ID stage. Decodes control fields, owns the 32x32 register file, and registers the results into the ID/EX latch.
// Latency: 1 cycle from if_id_* to id_ex_*. The register file reads combinationally; writes commit on the rising edge.
// Backpressure: none. The latch captures every cycle, and a branch-taken flush turns the captured control fields into a bubble.
// Optional feature: `DECODE_REGFILE_BYPASS_EN enables write-through forwarding from MEM/WB into same-cycle reads.
module decode_stage #(
  parameter int NUM_REGS = 32,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       if_id_instr,
  input  logic [31:0]       if_id_npc,
  input  logic              ex_mem_pc_src,
  input  logic              mem_wb_reg_write,
  input  logic [4:0]        mem_wb_write_reg,
  input  logic [DATA_W-1:0] mem_wb_write_data,
  output logic [1:0]        id_ex_wb,
  output logic [2:0]        id_ex_m,
  output logic [3:0]        id_ex_ex,
  output logic [31:0]       id_ex_npc,
  output logic [DATA_W-1:0] id_ex_readdat1,
  output logic [DATA_W-1:0] id_ex_readdat2,
  output logic [DATA_W-1:0] id_ex_sign_ext,
  output logic [4:0]        id_ex_instr_2016,
  output logic [4:0]        id_ex_instr_1511
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;

  logic [5:0]        opcode;
  logic [4:0]        rs;
  logic [4:0]        rt;
  logic [1:0]        wb_ctl;
  logic [2:0]        m_ctl;
  logic [3:0]        ex_ctl;
  logic [DATA_W-1:0] rd_dat1;
  logic [DATA_W-1:0] rd_dat2;
  logic [DATA_W-1:0] sign_ext;
  logic              wr_en;

  logic [DATA_W-1:0] regs [NUM_REGS];

  assign opcode   = if_id_instr[31:26];
  assign rs       = if_id_instr[25:21];
  assign rt       = if_id_instr[20:16];
  assign sign_ext = {{(DATA_W-16){if_id_instr[15]}}, if_id_instr[15:0]};

  // r0 is hardwired to zero, so writes aimed at it are dropped here
  assign wr_en = mem_wb_reg_write && (mem_wb_write_reg != 5'd0);

  // Decode the opcode into the WB/M/EX control fields; unknown opcodes become a bubble
  always_comb begin
    wb_ctl = 2'b00;
    m_ctl  = 3'b000;
    ex_ctl = 4'b0000;
    case (opcode)
      OP_RTYPE: begin ex_ctl = 4'b1100; m_ctl = 3'b000; wb_ctl = 2'b10; end
      OP_LW:    begin ex_ctl = 4'b0001; m_ctl = 3'b010; wb_ctl = 2'b11; end
      OP_SW:    begin ex_ctl = 4'b0001; m_ctl = 3'b001; wb_ctl = 2'b00; end
      OP_BEQ:   begin ex_ctl = 4'b0010; m_ctl = 3'b100; wb_ctl = 2'b00; end
      default:  begin ex_ctl = 4'b0000; m_ctl = 3'b000; wb_ctl = 2'b00; end
    endcase
  end

  // Two combinational read ports; r0 always reads zero
  always_comb begin
    rd_dat1 = (rs == 5'd0) ? '0 : regs[rs];
    rd_dat2 = (rt == 5'd0) ? '0 : regs[rt];
`ifdef DECODE_REGFILE_BYPASS_EN
    // Forward the write-back value so the latch sees it at the same edge it is written
    if (wr_en && (mem_wb_write_reg == rs)) rd_dat1 = mem_wb_write_data;
    if (wr_en && (mem_wb_write_reg == rt)) rd_dat2 = mem_wb_write_data;
`endif
  end

  // Register file write port; reset clears every entry
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[mem_wb_write_reg] <= mem_wb_write_data;
    end
  end

  // ID/EX latch; a flush zeroes only the control fields, while the data fields still pass through
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      id_ex_wb         <= '0;
      id_ex_m          <= '0;
      id_ex_ex         <= '0;
      id_ex_npc        <= '0;
      id_ex_readdat1   <= '0;
      id_ex_readdat2   <= '0;
      id_ex_sign_ext   <= '0;
      id_ex_instr_2016 <= '0;
      id_ex_instr_1511 <= '0;
    end else begin
      if (ex_mem_pc_src) begin
        id_ex_wb <= '0;
        id_ex_m  <= '0;
        id_ex_ex <= '0;
      end else begin
        id_ex_wb <= wb_ctl;
        id_ex_m  <= m_ctl;
        id_ex_ex <= ex_ctl;
      end
      id_ex_npc        <= if_id_npc;
      id_ex_readdat1   <= rd_dat1;
      id_ex_readdat2   <= rd_dat2;
      id_ex_sign_ext   <= sign_ext;
      id_ex_instr_2016 <= if_id_instr[20:16];
      id_ex_instr_1511 <= if_id_instr[15:11];
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Purpose: directed self-checking bench for decode_stage with hand-computed expectations.
// Latency: inputs are driven 1 time unit after a rising edge, and outputs are checked 1 time unit after the next rising edge.
// Backpressure: not applicable; the DUT captures every cycle.
module tb_decode_stage;

  logic        clk;
  logic        rst;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_npc;
  logic        ex_mem_pc_src;
  logic        mem_wb_reg_write;
  logic [4:0]  mem_wb_write_reg;
  logic [31:0] mem_wb_write_data;
  logic [1:0]  id_ex_wb;
  logic [2:0]  id_ex_m;
  logic [3:0]  id_ex_ex;
  logic [31:0] id_ex_npc;
  logic [31:0] id_ex_readdat1;
  logic [31:0] id_ex_readdat2;
  logic [31:0] id_ex_sign_ext;
  logic [4:0]  id_ex_instr_2016;
  logic [4:0]  id_ex_instr_1511;

  int checks = 0;
  int failures = 0;

  decode_stage dut (
    .clk               (clk),
    .rst               (rst),
    .if_id_instr       (if_id_instr),
    .if_id_npc         (if_id_npc),
    .ex_mem_pc_src     (ex_mem_pc_src),
    .mem_wb_reg_write  (mem_wb_reg_write),
    .mem_wb_write_reg  (mem_wb_write_reg),
    .mem_wb_write_data (mem_wb_write_data),
    .id_ex_wb          (id_ex_wb),
    .id_ex_m           (id_ex_m),
    .id_ex_ex          (id_ex_ex),
    .id_ex_npc         (id_ex_npc),
    .id_ex_readdat1    (id_ex_readdat1),
    .id_ex_readdat2    (id_ex_readdat2),
    .id_ex_sign_ext    (id_ex_sign_ext),
    .id_ex_instr_2016  (id_ex_instr_2016),
    .id_ex_instr_1511  (id_ex_instr_1511)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge, then settle just past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] instr, input logic [31:0] npc, input logic flush,
                       input logic we, input logic [4:0] wreg, input logic [31:0] wdat);
    if_id_instr       = instr;
    if_id_npc         = npc;
    ex_mem_pc_src     = flush;
    mem_wb_reg_write  = we;
    mem_wb_write_reg  = wreg;
    mem_wb_write_data = wdat;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_wb"},   {30'd0, id_ex_wb}, 32'd0);
    check({tag, "_m"},    {29'd0, id_ex_m},  32'd0);
    check({tag, "_ex"},   {28'd0, id_ex_ex}, 32'd0);
    check({tag, "_npc"},  id_ex_npc,         32'd0);
    check({tag, "_rd1"},  id_ex_readdat1,    32'd0);
    check({tag, "_rd2"},  id_ex_readdat2,    32'd0);
    check({tag, "_sext"}, id_ex_sign_ext,    32'd0);
    check({tag, "_2016"}, {27'd0, id_ex_instr_2016}, 32'd0);
    check({tag, "_1511"}, {27'd0, id_ex_instr_1511}, 32'd0);
  endtask

  initial begin
    // Hold reset while random inputs toggle
    rst = 1'b0;
    drive($urandom, $urandom, 1'($urandom), 1'b1, 5'($urandom), $urandom);
    for (int i = 0; i < 4; i++) begin
      drive($urandom, $urandom, 1'($urandom), 1'b1, 5'($urandom_range(1, 31)), $urandom);
      step();
    end
    check_all_zero("reset");

    // Release reset and write r5 = 0xAA
    drive(32'h0000_0000, 32'h0, 1'b0, 1'b1, 5'd5, 32'h0000_00AA);
    rst = 1'b1;
    step();
    drive(32'h00A0_0000, 32'h4, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("r5_read", id_ex_readdat1, 32'h0000_00AA);
    check("r5_npc",  id_ex_npc,      32'h4);

    // lw decode
    drive(32'h8C22_FFFC, 32'h10, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("lw_wb",   {30'd0, id_ex_wb}, 32'h3);
    check("lw_m",    {29'd0, id_ex_m},  32'h2);
    check("lw_ex",   {28'd0, id_ex_ex}, 32'h1);
    check("lw_sext", id_ex_sign_ext,    32'hFFFF_FFFC);
    check("lw_2016", {27'd0, id_ex_instr_2016}, 32'd2);
    check("lw_npc",  id_ex_npc,         32'h10);

    // R-type: r1 = 3, r2 = 4, then add r3, r1, r2
    drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd1, 32'd3);
    step();
    drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd2, 32'd4);
    step();
    drive(32'h0022_1820, 32'h14, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("rt_rd1",  id_ex_readdat1, 32'd3);
    check("rt_rd2",  id_ex_readdat2, 32'd4);
    check("rt_1511", {27'd0, id_ex_instr_1511}, 32'd3);
    check("rt_ex",   {28'd0, id_ex_ex}, 32'hC);
    check("rt_wb",   {30'd0, id_ex_wb}, 32'h2);
    check("rt_m",    {29'd0, id_ex_m},  32'h0);

    // sw decode with a positive immediate
    drive(32'hAC22_0010, 32'h18, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("sw_ex",   {28'd0, id_ex_ex}, 32'h1);
    check("sw_m",    {29'd0, id_ex_m},  32'h1);
    check("sw_wb",   {30'd0, id_ex_wb}, 32'h0);
    check("sw_sext", id_ex_sign_ext,    32'h0000_0010);

    // Unknown opcode: bubble control, while the data fields still pass through
    drive(32'hFC22_1234, 32'h1C, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("bub_ex",   {28'd0, id_ex_ex}, 32'h0);
    check("bub_m",    {29'd0, id_ex_m},  32'h0);
    check("bub_wb",   {30'd0, id_ex_wb}, 32'h0);
    check("bub_sext", id_ex_sign_ext,    32'h0000_1234);
    check("bub_rd1",  id_ex_readdat1,    32'd3);

    // A write to r0 is ignored
    drive(32'h0, 32'h0, 1'b0, 1'b1, 5'd0, 32'hDEAD_BEEF);
    step();
    drive(32'h0000_0000, 32'h0, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("r0_read", id_ex_readdat1, 32'd0);

    // Same-cycle write of r7 while r7 is being decoded
    drive(32'h00E0_0000, 32'h20, 1'b0, 1'b1, 5'd7, 32'h1234);
    step();
`ifdef DECODE_REGFILE_BYPASS_EN
    check("same_cyc", id_ex_readdat1, 32'h1234);
`else
    check("same_cyc", id_ex_readdat1, 32'h0);
`endif
    drive(32'h00E0_0000, 32'h24, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("next_cyc", id_ex_readdat1, 32'h1234);

    // beq without a flush
    drive(32'h1022_0002, 32'h28, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("beq_ex", {28'd0, id_ex_ex}, 32'h2);
    check("beq_m",  {29'd0, id_ex_m},  32'h4);

    // beq with a flush and a concurrent write-back of r9
    drive(32'h1022_0002, 32'h2C, 1'b1, 1'b1, 5'd9, 32'h99);
    step();
    check("fl_wb",   {30'd0, id_ex_wb}, 32'h0);
    check("fl_m",    {29'd0, id_ex_m},  32'h0);
    check("fl_ex",   {28'd0, id_ex_ex}, 32'h0);
    check("fl_sext", id_ex_sign_ext,    32'h2);
    check("fl_npc",  id_ex_npc,         32'h2C);
    check("fl_rd2",  id_ex_readdat2,    32'd4);
    drive(32'h0120_0000, 32'h30, 1'b0, 1'b0, 5'd0, 32'h0);
    step();
    check("fl_r9", id_ex_readdat1, 32'h99);
    check("fl_after_ex", {28'd0, id_ex_ex}, 32'hC);

    // Asynchronous reset mid-operation clears the latch and the register file
    drive(32'h00A0_0000, 32'h40, 1'b0, 1'b0, 5'd0, 32'h0);
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("async");
    step();
    rst = 1'b1;
    step();
    check("post_rst_r5",  id_ex_readdat1, 32'd0);
    check("post_rst_npc", id_ex_npc,      32'h40);
    check("post_rst_ex",  {28'd0, id_ex_ex}, 32'hC);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
# decode_stage

Instruction decode stage of the five-stage MIPS pipeline. It consumes the IF/ID latch outputs (`if_id_instr`, `if_id_npc`) produced by fetch and decodes the opcode into control fields. It owns the 32x32 register file, written back from MEM/WB, and registers everything into the ID/EX latch for execute. It also accepts the branch-taken flush, so a taken branch squashes the instruction currently in decode.

## Interface
Parameters:
- `NUM_REGS`, default 32: register file depth. The address width is fixed at 5 bits.
- `DATA_W`, default 32: register and datapath width.

Ports:
- `clk` input, 1: single clock. Everything updates on the rising edge.
- `rst` input, 1: asynchronous, active-low reset.
- `if_id_instr` input, 32: instruction from the IF/ID latch.
- `if_id_npc` input, 32: PC+1 from the IF/ID latch.
- `ex_mem_pc_src` input, 1: branch taken; flushes decode.
- `mem_wb_reg_write` input, 1: write-back enable.
- `mem_wb_write_reg` input, 5: write-back destination register.
- `mem_wb_write_data` input, 32: write-back data.
- `id_ex_wb` output, 2: {RegWrite, MemtoReg}.
- `id_ex_m` output, 3: {Branch, MemRead, MemWrite}.
- `id_ex_ex` output, 4: {RegDst, ALUOp[1:0], ALUSrc}.
- `id_ex_npc` output, 32: registered `if_id_npc`.
- `id_ex_readdat1` output, 32: value of rs (instr[25:21]).
- `id_ex_readdat2` output, 32: value of rt (instr[20:16]).
- `id_ex_sign_ext` output, 32: instr[15:0] sign-extended.
- `id_ex_instr_2016` output, 5: instr[20:16].
- `id_ex_instr_1511` output, 5: instr[15:11].

## Operation
Opcode is instr[31:26]. Control decode is combinational; results are registered into the ID/EX latch.
- 6'b000000 (R-type): ex=4'b1100, m=3'b000, wb=2'b10.
- 6'b100011 (lw): ex=4'b0001, m=3'b010, wb=2'b11.
- 6'b101011 (sw): ex=4'b0001, m=3'b001, wb=2'b00.
- 6'b000100 (beq): ex=4'b0010, m=3'b100, wb=2'b00.
- Any other opcode: all control fields are 0 (bubble). Data fields still pass through.

Register file:
- 32 entries, two combinational read ports (rs, rt) and one write port.
- Write happens on the rising edge when `mem_wb_reg_write`=1 and `mem_wb_write_reg`≠0.
- Register 0 always reads 0; writes to it are ignored.

Sign extension: {{16{instr[15]}}, instr[15:0]}.

Flush: when `ex_mem_pc_src`=1 at an edge, the latch captures wb, m and ex as all zero. Data fields are captured normally. A register file write in the same cycle still takes effect.

Priority: reset > flush > normal capture. There is no stall input; the latch captures every cycle.

## Timing
- Latency is 1 cycle: an instruction on `if_id_instr` before edge N appears on the `id_ex_*` outputs after edge N.
- A register file write at edge N is visible to reads issued from edge N onward. Read behaviour in the same cycle as a write is set by the configuration below.
- Reset (`rst`=0) asynchronously clears every `id_ex_*` output to 0 and all 32 registers to 0.
- Reset asserted mid-operation discards the in-flight instruction. The first capture after `rst` rises is a normal capture.
- Simultaneous flush and write-back: the latch carries a bubble and the register is still written.

## Configuration
- `DECODE_REGFILE_BYPASS_EN` defined: write-through bypass. If `mem_wb_reg_write`=1, `mem_wb_write_reg`≠0, and it matches rs (or rt) in the same cycle, the corresponding read returns `mem_wb_write_data`. The ID/EX latch therefore captures the new value at the same edge the register is written.
- Not defined: reads return the stored register contents. A same-cycle write is seen by the latch one cycle later, and the hazard is left to software/NOP insertion.

## Test plan
- Reset: hold `rst`=0 with random inputs; all outputs are 0. Release, write r5=32'h0000_00AA, then decode instr 32'h00A0_0000; `id_ex_readdat1`=32'hAA.
- lw decode: instr 32'h8C22_FFFC, npc 32'h10. Next cycle: wb=2'b11, m=3'b010, ex=4'b0001, sign_ext=32'hFFFF_FFFC, instr_2016=5'd2, npc=32'h10.
- R-type: r1=3, r2=4, instr 32'h0022_1820. Required: readdat1=3, readdat2=4, instr_1511=5'd3, ex=4'b1100, wb=2'b10.
- r0 write: write r0=32'hDEAD_BEEF, then read rs=0; readdat1=0.
- Same-cycle write and read: write r7=32'h1234 while decoding rs=7. With the macro, readdat1=32'h1234 after that edge; without it, the old value, with 32'h1234 on the next decode.
- Flush: beq 32'h1022_0002 with `ex_mem_pc_src`=1. Next cycle: wb=0, m=0, ex=0, sign_ext=32'h2; a concurrent write-back of r9 is still committed.
